// File: rtl/par_to_ser_tx_pkg.sv
// Shared types for the stream chapter transmitters.
// Holds the tx FSM state type and default widths.
package par_to_ser_tx_pkg;

  localparam int TX_DW    = 8;
  localparam int TX_DIV_W = 8;
  localparam int CNT_W    = $clog2(TX_DW);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

endpackage

// File: rtl/par_to_ser_tx_bit_period_cnt.sv
// Bit-period divider: counts 0..period, tick on the last
// cycle of each bit. Ports: clk, rst_n, clr, en, period, tick.
module bit_period_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/par_to_ser_tx.sv
// MSB-first parallel-to-serial transmitter with bit strobes.
// Ports: clk, rst_n, in_valid/in_ready/in_data, div, ser_out, ser_valid, frame, done.
module par_to_ser_tx
  import par_to_ser_tx_pkg::*;
#(
  parameter int  DW    = TX_DW,
  parameter int  DIV_W = TX_DIV_W,
  parameter type dw_t  = logic [DW-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  dw_t              in_data,
  input  logic [DIV_W-1:0] div,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame,
  output logic             done
);

  localparam int BCW = $clog2(DW);

  tx_state_e        state;
  dw_t              sreg;
  logic [BCW-1:0]   bit_cnt;
  logic [DIV_W-1:0] period_r;
  logic             tick;
  logic             last;
  logic             accept;

  bit_period_cnt #(
    .DIV_W (DIV_W)
  ) u_bpc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (frame),
    .period (period_r),
    .tick   (tick)
  );

  assign frame     = (state == SHIFT);
  assign ser_valid = frame && tick;
  assign last      = (bit_cnt == BCW'(DW - 1));
  assign done      = ser_valid && last;
  assign in_ready  = !frame || done;
  assign accept    = in_valid && in_ready;
  // A finished word has been shifted fully out, so the MSB
  // is already 0 whenever the block is idle.
  assign ser_out   = sreg[DW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      bit_cnt  <= '0;
      period_r <= '0;
    end else if (accept) begin
      state    <= SHIFT;
      sreg     <= in_data;
      bit_cnt  <= '0;
      period_r <= div;
    end else if (ser_valid) begin
      sreg    <= {sreg[DW-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
      if (last) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/par_to_ser_tx.md
Name: par_to_ser_tx

Overview:
- Parallel-to-serial transmitter that feeds the team's serial-in/parallel-out shift register.
- Accepts DW-bit words over a valid/ready handshake and emits them MSB-first, one bit per programmable bit period.
- Each bit comes with a one-cycle strobe that drives the downstream shift enable directly. A done pulse marks word completion and can drive the downstream load/consume logic.

Parameters:
- DW, 8, word width in bits (must be ≥ 2).
- DIV_W, 8, width of the bit-period divider field.
- dw_t, logic [DW-1:0], word type.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DW  word to transmit (dw_t).
- div  input  DIV_W  bit period minus one, in clk cycles (0 = one bit per cycle).
- ser_out  output  1  serial data bit, MSB first.
- ser_valid  output  1  one-cycle strobe; ser_out is valid for sampling in this cycle.
- frame  output  1  high while a word is being transmitted.
- done  output  1  one-cycle pulse coincident with the last bit's ser_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state is reset asynchronously.
- Reset values: state=IDLE, in_ready=1 after reset release, ser_out=0, ser_valid=0, frame=0, done=0. Shift register, bit counter and divider counter all reset to 0.
- States:
  - IDLE: in_ready=1, frame=0, ser_out=0.
  - SHIFT: frame=1.
- Accept: a transfer happens when in_valid && in_ready. On the accepting edge:
  - Latch in_data into the internal shift register.
  - Latch div into period_r.
  - Clear bit_cnt=0 and div_cnt=0.
  - Go to SHIFT.
- Latency: ser_out shows in_data[DW-1] in the first cycle after acceptance.
- Bit timing:
  - Each bit is held for period_r+1 cycles.
  - div_cnt counts 0..period_r.
  - ser_valid=1 only in the cycle where div_cnt==period_r, which is the last cycle of the bit.
  - On that edge the shift register moves left by one, so ser_out always equals the register MSB, and bit_cnt increments.
- Word end:
  - When ser_valid && bit_cnt==DW-1, done=1 in the same cycle.
  - Total word duration is DW*(period_r+1) cycles.
- Back-to-back: in_ready is also 1 in SHIFT during the final ser_valid cycle of the word.
  - If a word is accepted there, the next cycle starts bit 0 of the new word in SHIFT. There is no idle gap, frame stays 1, and the new div value is latched.
  - If no word is accepted there, the next state is IDLE.
- In SHIFT, in_ready=0 in every cycle except that final one. in_data is ignored while in_ready=0.
- Changing div mid-word has no effect on the current word; period_r is sampled only at acceptance.
- div=0: ser_valid is high every cycle of the frame, giving DW consecutive strobes.
- Reset mid-word: the word is aborted immediately and all outputs return to their reset values. No done pulse is produced.
- Handshake rule: in_valid may depend on in_ready. in_ready is a function of registered state only (no combinational path from in_valid).

Decomposition:
- Shared package for the stream chapter:
  - typedef tx_state_e {IDLE, SHIFT}.
  - Localparam CNT_W = $clog2(DW).
- One natural sub-module: bit_period_cnt. It takes period_r and enable, and outputs the tick (div_cnt==period_r), wrapping to 0.
- The top holds the FSM, the shift register and the bit counter.

Test Plan:
- Single word, DW=8, div=0, in_data=8'hA5 → frame high 8 cycles; ser_out 1,0,1,0,0,1,0,1 with ser_valid=1 each cycle; done on the 8th; downstream shift register q=8'hA5 after done.
- div=3, in_data=8'h81 → each bit held 4 cycles; ser_valid on every 4th cycle; first bit 1, bits 2-7 0, last bit 1; done at cycle 32 after accept.
- Back-to-back, div=0: 8'hF0 then 8'h0F presented with in_valid held → 16 contiguous strobes; frame never drops; in_ready high only on strobe 8 (and in IDLE); done pulses at strobes 8 and 16.
- div changed from 1 to 5 mid-word → current word keeps 2-cycle bits; next accepted word uses 6-cycle bits.
- rst_n asserted at bit 4 of 8'hFF → all outputs 0 asynchronously with no done pulse; after release in_ready=1 and a new word 8'h3C transmits correctly.
- in_valid=1 while busy (not the final strobe) → in_ready=0, word not accepted; in_data changes ignored; the word is accepted exactly at the final strobe cycle.
